udp_box_writer: RTL and testbench



---
 rtl/box_pkg.sv | 39 +++
 rtl/box_word_mux.sv | 63 ++++++
 rtl/udp_box_writer.sv | 126 ++++++++++++
 tb/tb_udp_box_writer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/box_pkg.sv
// Shared definitions for the draw-box wire format, used by the box writer and the receive-side parser.
package box_pkg;

  localparam int BOX_BYTES = 6;
  localparam int BOX_W     = 8 * BOX_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_FIN
  } box_state_t;

  // Packs {sx, sy, ex, ey, R, G, B} MSB first; each colour keeps its top cdep bits.
  function automatic logic [BOX_W-1:0] box_word(
    input logic [15:0] sx,
    input logic [15:0] sy,
    input logic [15:0] ex,
    input logic [15:0] ey,
    input logic [23:0] rgb,
    input int          xw,
    input int          yw,
    input int          cdep
  );
    logic [BOX_W-1:0] w;
    logic [7:0]       ch;
    w = {32'd0, sx} & ((48'd1 << xw) - 48'd1);
    w = (w << yw) | ({32'd0, sy} & ((48'd1 << yw) - 48'd1));
    w = (w << xw) | ({32'd0, ex} & ((48'd1 << xw) - 48'd1));
    w = (w << yw) | ({32'd0, ey} & ((48'd1 << yw) - 48'd1));
    for (int c = 2; c >= 0; c--) begin
      ch = rgb[c*8 +: 8] >> (8 - cdep);
      w  = (w << cdep) | {40'd0, ch};
    end
    return w;
  endfunction

endpackage

// File: rtl/box_word_mux.sv
// Tracks the current byte as (box, byte-in-box) and presents the byte that follows it.
module box_word_mux
  import box_pkg::*;
#(
  parameter int BOX_NUM = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_adv,
  input  logic [BOX_NUM*BOX_W-1:0] i_words,
  output logic [7:0]               o_next_byte
);

  localparam int BW = $clog2(BOX_NUM + 1);

  logic [BW-1:0]    r_box;
  logic [2:0]       r_sub;
  logic [BW-1:0]    w_nbox;
  logic [2:0]       w_nsub;
  logic [BOX_W-1:0] w_word;
  logic             w_valid;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_box <= '0;
      r_sub <= '0;
    end else if (i_adv) begin
      if (r_sub == 3'd5) begin
        r_sub <= '0;
        r_box <= r_box + BW'(1);
      end else begin
        r_sub <= r_sub + 3'd1;
      end
    end
  end

  // Past the last box the lookahead yields zero, which is what tx_data shows after the packet.
  always_comb begin
    w_nbox  = (r_sub == 3'd5) ? r_box + BW'(1) : r_box;
    w_nsub  = (r_sub == 3'd5) ? 3'd0 : r_sub + 3'd1;
    w_word  = '0;
    w_valid = 1'b0;
    for (int b = 0; b < BOX_NUM; b++) begin
      if (int'(w_nbox) == b) begin
        w_word  = i_words[b*BOX_W +: BOX_W];
        w_valid = 1'b1;
      end
    end
    o_next_byte = 8'h00;
    if (w_valid) begin
      case (w_nsub)
        3'd0:    o_next_byte = w_word[47:40];
        3'd1:    o_next_byte = w_word[39:32];
        3'd2:    o_next_byte = w_word[31:24];
        3'd3:    o_next_byte = w_word[23:16];
        3'd4:    o_next_byte = w_word[15:8];
        default: o_next_byte = w_word[7:0];
      endcase
    end
  end

endmodule

// File: rtl/udp_box_writer.sv
// Snapshots the draw-box set on trig and streams it to the UDP transmitter, one byte per read strobe.
module udp_box_writer
  import box_pkg::*;
#(
  parameter int BOX_NUM = 1,
  parameter int H_ACT   = 1280,
  parameter int V_ACT   = 720,
  parameter int C_DEP   = 2,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             trig,
  input  logic [BOX_NUM*$clog2(H_ACT)-1:0] start_xs,
  input  logic [BOX_NUM*$clog2(V_ACT)-1:0] start_ys,
  input  logic [BOX_NUM*$clog2(H_ACT)-1:0] end_xs,
  input  logic [BOX_NUM*$clog2(V_ACT)-1:0] end_ys,
  input  logic [BOX_NUM*24-1:0]            colors,
  output logic                             aquire,
  input  logic                             tx_read_en,
  output logic [7:0]                       tx_data,
  output logic [15:0]                      tx_data_len,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int XW     = $clog2(H_ACT);
  localparam int YW     = $clog2(V_ACT);
  localparam int NBYTES = BOX_BYTES * BOX_NUM;
  localparam int IDXW   = $clog2(NBYTES + 1);
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  generate
    if (2*XW + 2*YW + 3*C_DEP != BOX_W) begin : g_bad_geometry
      $error("udp_box_writer: 2*XW+2*YW+3*C_DEP must equal 48");
    end
  endgenerate

  box_state_t               r_state, w_state_nxt;
  logic [BOX_NUM*BOX_W-1:0] r_shadow, w_live;
  logic [IDXW-1:0]          r_byte_idx;
  logic [TW-1:0]            r_timer;
  logic [7:0]               r_tx_data, w_next_byte;
  logic                     r_error;
  logic                     w_snap, w_take, w_timeout, w_overread;

  always_comb begin
    w_live = '0;
    for (int b = 0; b < BOX_NUM; b++) begin
      w_live[b*BOX_W +: BOX_W] = box_word(16'(start_xs[b*XW +: XW]), 16'(start_ys[b*YW +: YW]),
                                          16'(end_xs[b*XW +: XW]), 16'(end_ys[b*YW +: YW]),
                                          colors[b*24 +: 24], XW, YW, C_DEP);
    end
  end

  assign w_snap     = (r_state == ST_IDLE) && trig;
  assign w_take     = tx_read_en && ((r_state == ST_WAIT) || (r_state == ST_SEND));
  assign w_timeout  = (r_state == ST_WAIT) && !tx_read_en && (r_timer == TW'(TIMEOUT - 1));
  assign w_overread = tx_read_en && ((r_state == ST_IDLE) || (r_state == ST_FIN));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (trig) w_state_nxt = ST_REQ;
      ST_REQ:  w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tx_read_en)     w_state_nxt = ST_SEND;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_SEND: if (tx_read_en && (r_byte_idx == IDXW'(NBYTES - 1))) w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte 0 is loaded straight from the live inputs so it is already valid in the REQ cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shadow   <= '0;
      r_byte_idx <= '0;
      r_timer    <= '0;
      r_tx_data  <= 8'h00;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_snap) begin
        r_shadow   <= w_live;
        r_byte_idx <= '0;
        r_timer    <= '0;
        r_tx_data  <= w_live[BOX_W-1 -: 8];
      end else begin
        if (w_take) begin
          r_byte_idx <= r_byte_idx + IDXW'(1);
          r_tx_data  <= w_next_byte;
        end else if (w_state_nxt == ST_IDLE) begin
          r_tx_data <= 8'h00;
        end
        if (((r_state == ST_REQ) || (r_state == ST_WAIT)) && (r_timer != '1)) begin
          r_timer <= r_timer + TW'(1);
        end
      end
      if (w_timeout || w_overread) r_error <= 1'b1;
    end
  end

  box_word_mux #(
    .BOX_NUM (BOX_NUM)
  ) u_mux (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_snap),
    .i_adv       (w_take),
    .i_words     (r_shadow),
    .o_next_byte (w_next_byte)
  );

  assign aquire      = (r_state == ST_REQ);
  assign busy        = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_SEND);
  assign done        = (r_state == ST_FIN);
  assign error       = r_error;
  assign tx_data     = r_tx_data;
  assign tx_data_len = 16'(NBYTES);

endmodule

// File: tb/tb_udp_box_writer.sv
// Directed-plus-random bench for udp_box_writer (2 boxes, short timeout) against an arithmetic packet model.
module tb_udp_box_writer;

  localparam int NB     = 2;
  localparam int NBYTES = 6 * NB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0;
  logic tx_read_en = 1'b0;

  logic [10:0] bsx [NB];
  logic [9:0]  bsy [NB];
  logic [10:0] bex [NB];
  logic [9:0]  bey [NB];
  logic [23:0] bcol[NB];

  logic [NB*11-1:0] start_xs, end_xs;
  logic [NB*10-1:0] start_ys, end_ys;
  logic [NB*24-1:0] colors;

  assign start_xs = {bsx[1], bsx[0]};
  assign start_ys = {bsy[1], bsy[0]};
  assign end_xs   = {bex[1], bex[0]};
  assign end_ys   = {bey[1], bey[0]};
  assign colors   = {bcol[1], bcol[0]};

  logic        aquire, busy, done, error;
  logic [7:0]  tx_data;
  logic [15:0] tx_data_len;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_b[NBYTES];

  always #5 clk = ~clk;

  udp_box_writer #(
    .BOX_NUM (NB),
    .H_ACT   (1280),
    .V_ACT   (720),
    .C_DEP   (2),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trig        (trig),
    .start_xs    (start_xs),
    .start_ys    (start_ys),
    .end_xs      (end_xs),
    .end_ys      (end_ys),
    .colors      (colors),
    .aquire      (aquire),
    .tx_read_en  (tx_read_en),
    .tx_data     (tx_data),
    .tx_data_len (tx_data_len),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet model: each box is a 48-bit number built by weighted sums, sent big-endian.
  function automatic void build_exp();
    longint w;
    for (int b = 0; b < NB; b++) begin
      w = (longint'(bsx[b]) << 37) + (longint'(bsy[b]) << 27) + (longint'(bex[b]) << 16) +
          (longint'(bey[b]) << 6) + (((longint'(bcol[b]) >> 22) & 3) << 4) +
          (((longint'(bcol[b]) >> 14) & 3) << 2) + ((longint'(bcol[b]) >> 6) & 3);
      for (int j = 0; j < 6; j++) exp_b[b*6 + j] = 8'((w >> (8 * (5 - j))) & 255);
    end
  endfunction

  task automatic randomize_boxes();
    for (int b = 0; b < NB; b++) begin
      bsx[b]  = 11'($urandom_range(1279, 0));
      bsy[b]  = 10'($urandom_range(719, 0));
      bex[b]  = 11'($urandom_range(1279, 0));
      bey[b]  = 10'($urandom_range(719, 0));
      bcol[b] = 24'($urandom);
    end
  endtask

  // Leaves the bench in the WAIT cycle with byte 0 presented.
  task automatic start_pkt();
    trig = 1'b1;
    tick();
    chk("aquire_req", aquire, 1);
    chk("busy_req", busy, 1);
    chk("byte0_in_req", tx_data, exp_b[0]);
    trig = 1'b0;
    tick();
    chk("aquire_drop", aquire, 0);
    chk("busy_wait", busy, 1);
  endtask

  // Pulls the whole packet with random gaps; returns in the FIN cycle.
  task automatic pull_all(input int gap_max, input logic exp_err);
    for (int k = 0; k < NBYTES; k++) begin
      chk($sformatf("byte%0d", k), tx_data, exp_b[k]);
      repeat ($urandom_range(gap_max, 0)) begin
        tick();
        chk($sformatf("byte%0d_hold", k), tx_data, exp_b[k]);
      end
      tx_read_en = 1'b1;
      tick();
      tx_read_en = 1'b0;
      if (k != NBYTES - 1) chk("no_early_done", done, 0);
    end
    chk("done_fin", done, 1);
    chk("busy_fin", busy, 0);
    chk("data_fin", tx_data, 8'h00);
    chk("error_fin", error, exp_err);
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      bsx[b] = '0; bsy[b] = '0; bex[b] = '0; bey[b] = '0; bcol[b] = '0;
    end
    tick();
    tick();
    chk("rst_aquire", aquire, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("data_len", tx_data_len, 16'd12);
    rst = 1'b0;
    tick();

    // Corner box plus an all-zero box with grey colour, against literal bytes.
    bsx[0] = 11'd1279; bsy[0] = 10'd719; bex[0] = 11'd0; bey[0] = 10'd0; bcol[0] = 24'hFFFFFF;
    bsx[1] = 11'd0;    bsy[1] = 10'd0;   bex[1] = 11'd0; bey[1] = 10'd0; bcol[1] = 24'hC0C0C0;
    exp_b = '{8'h9F, 8'hF6, 8'h78, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F};
    start_pkt();
    pull_all(0, 1'b0);
    tick();
    chk("done_pulse_end", done, 0);

    repeat (4) begin
      randomize_boxes();
      build_exp();
      start_pkt();
      pull_all(3, 1'b0);
      tick();
      chk("done_pulse_end", done, 0);
    end

    // Inputs changed after the snapshot must not reach the packet in flight.
    randomize_boxes();
    build_exp();
    start_pkt();
    bsx[0] = bsx[0] ^ 11'h2A5;
    pull_all(1, 1'b0);
    tick();
    build_exp();
    start_pkt();
    pull_all(0, 1'b0);
    tick();

    // trig held high re-arms right after FIN.
    randomize_boxes();
    build_exp();
    trig = 1'b1;
    tick();
    tick();
    pull_all(0, 1'b0);
    tick();
    chk("rearm_idle_aquire", aquire, 0);
    chk("rearm_idle_busy", busy, 0);
    tick();
    chk("rearm_aquire", aquire, 1);
    chk("rearm_byte0", tx_data, exp_b[0]);
    trig = 1'b0;
    tick();
    pull_all(2, 1'b0);
    tick();

    // Starvation: no strobes after the request.
    randomize_boxes();
    build_exp();
    trig = 1'b1;
    tick();
    chk("to_aquire", aquire, 1);
    trig = 1'b0;
    repeat (15) tick();
    chk("to_not_early", error, 0);
    chk("to_busy_before", busy, 1);
    tick();
    chk("to_error", error, 1);
    chk("to_busy_after", busy, 0);
    chk("to_data", tx_data, 8'h00);
    tick();
    randomize_boxes();
    build_exp();
    start_pkt();
    pull_all(2, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("error_cleared", error, 0);
    tick();

    // Over-read: one strobe beyond the packet.
    randomize_boxes();
    build_exp();
    start_pkt();
    pull_all(0, 1'b0);
    tx_read_en = 1'b1;
    tick();
    tx_read_en = 1'b0;
    chk("ovr_error", error, 1);
    chk("ovr_data", tx_data, 8'h00);
    chk("ovr_no_done", done, 0);
    repeat (3) tick();
    chk("ovr_sticky", error, 1);

    // Reset in the middle of a packet.
    randomize_boxes();
    build_exp();
    start_pkt();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_byte%0d", k), tx_data, exp_b[k]);
      tx_read_en = 1'b1;
      tick();
    end
    tx_read_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_aquire", aquire, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_error", error, 0);
    chk("mid_data", tx_data, 8'h00);
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("mid_no_done", done, 0);
    end

    randomize_boxes();
    build_exp();
    start_pkt();
    pull_all(1, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
